// File: rtl/cc_life_manager_pkg.sv
// -----------------------------------------------------------------------------
// cc_life_manager_pkg
// Shared definitions for the life manager and for any block that needs to
// agree with it (HUD, game controller):
//   - life_state_e : FSM state encoding (PLAY=00, GRACE=01, GAMEOVER=10)
//   - LIFE_* / GRACE_* default constants, so every consumer uses identical
//     values when it does not override them.
// -----------------------------------------------------------------------------
package cc_life_manager_pkg;

  localparam int LIFE_DATAWIDTH_DEF  = 3;
  localparam int LIFE_INIT_DEF       = 3;
  localparam int LIFE_MAX_DEF        = 7;
  localparam int GRACE_TICKS_DEF     = 60;
  localparam int GRACE_DATAWIDTH_DEF = 6;

  typedef enum logic [1:0] {
    STATE_PLAY     = 2'b00,
    STATE_GRACE    = 2'b01,
    STATE_GAMEOVER = 2'b10
  } life_state_e;

endpackage

// File: rtl/cc_grace_timer.sv
// -----------------------------------------------------------------------------
// cc_grace_timer
// Loadable down-counter that measures the invulnerability window in frame
// ticks. A load has priority over a tick; the counter never wraps below 0.
// Ports:
//   clk_i      : system clock
//   rst_i      : synchronous active-high reset (counter -> 0)
//   load_i     : load load_val_i on the next edge
//   load_val_i : value to load
//   tick_i     : decrement enable (one frame tick)
//   zero_o     : counter is 0
//   last_o     : counter is 1 (the next tick empties it)
// -----------------------------------------------------------------------------
module cc_grace_timer #(
  parameter int GRACE_DATAWIDTH = 6
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       load_i,
  input  logic [GRACE_DATAWIDTH-1:0] load_val_i,
  input  logic                       tick_i,
  output logic                       zero_o,
  output logic                       last_o
);

  logic [GRACE_DATAWIDTH-1:0] count_q;
  logic [GRACE_DATAWIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - GRACE_DATAWIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);
  assign last_o = (count_q == GRACE_DATAWIDTH'(1));

endmodule

// File: rtl/cc_life_manager.sv
// -----------------------------------------------------------------------------
// cc_life_manager
// Holds the player's life count, applies hit (decrement) and bonus
// (saturating increment) events, runs a frame-tick grace window after each
// lost life and drives registered status flags.
// Event priority within a cycle: reset > restart > hit > bonus; tick is
// independent and only counts while in GRACE.
// Ports:
//   CC_LIFE_MANAGER_CLOCK_50         : system clock (rising edge)
//   CC_LIFE_MANAGER_RESET_InHigh     : synchronous reset, active high
//   CC_LIFE_MANAGER_hit_InHigh       : pulse, frog collided or drowned
//   CC_LIFE_MANAGER_bonus_InHigh     : pulse, extra life earned
//   CC_LIFE_MANAGER_restart_InHigh   : pulse, new game requested
//   CC_LIFE_MANAGER_tick_InHigh      : frame-tick strobe
//   CC_LIFE_MANAGER_lives_OutBUS     : current life count
//   CC_LIFE_MANAGER_alive_OutHigh    : lives != 0
//   CC_LIFE_MANAGER_gameover_OutHigh : in GAMEOVER
//   CC_LIFE_MANAGER_invuln_OutHigh   : in GRACE
//   CC_LIFE_MANAGER_lifelost_OutHigh : one-cycle pulse per accepted hit
// Handshake: all inputs are single-cycle strobes with no back-pressure; every
// sampled event appears on the registered outputs one cycle after its edge.
// -----------------------------------------------------------------------------
module cc_life_manager
  import cc_life_manager_pkg::*;
#(
  parameter int LIFE_DATAWIDTH  = LIFE_DATAWIDTH_DEF,
  parameter int LIFE_INIT       = LIFE_INIT_DEF,
  parameter int LIFE_MAX        = LIFE_MAX_DEF,
  parameter int GRACE_TICKS     = GRACE_TICKS_DEF,
  parameter int GRACE_DATAWIDTH = GRACE_DATAWIDTH_DEF
) (
  input  logic                      CC_LIFE_MANAGER_CLOCK_50,
  input  logic                      CC_LIFE_MANAGER_RESET_InHigh,
  input  logic                      CC_LIFE_MANAGER_hit_InHigh,
  input  logic                      CC_LIFE_MANAGER_bonus_InHigh,
  input  logic                      CC_LIFE_MANAGER_restart_InHigh,
  input  logic                      CC_LIFE_MANAGER_tick_InHigh,
  output logic [LIFE_DATAWIDTH-1:0] CC_LIFE_MANAGER_lives_OutBUS,
  output logic                      CC_LIFE_MANAGER_alive_OutHigh,
  output logic                      CC_LIFE_MANAGER_gameover_OutHigh,
  output logic                      CC_LIFE_MANAGER_invuln_OutHigh,
  output logic                      CC_LIFE_MANAGER_lifelost_OutHigh
);

  localparam logic [LIFE_DATAWIDTH-1:0]  LIVES_INIT = LIFE_DATAWIDTH'(LIFE_INIT);
  localparam logic [LIFE_DATAWIDTH-1:0]  LIVES_MAX  = LIFE_DATAWIDTH'(LIFE_MAX);
  localparam logic [LIFE_DATAWIDTH-1:0]  LIVES_ONE  = LIFE_DATAWIDTH'(1);
  localparam logic [GRACE_DATAWIDTH-1:0] GRACE_LOAD = GRACE_DATAWIDTH'(GRACE_TICKS);

  logic clk;
  logic rst;
  assign clk = CC_LIFE_MANAGER_CLOCK_50;
  assign rst = CC_LIFE_MANAGER_RESET_InHigh;

  life_state_e               state_q,    state_d;
  logic [LIFE_DATAWIDTH-1:0] lives_q,    lives_d;
  logic                      alive_q,    alive_d;
  logic                      gameover_q, gameover_d;
  logic                      invuln_q,   invuln_d;
  logic                      lifelost_q, lifelost_d;

  logic                       tmr_load;
  logic [GRACE_DATAWIDTH-1:0] tmr_load_val;
  logic                       tmr_tick;
  logic                       tmr_zero;
  logic                       tmr_last;

  // Ticks only count while invulnerable; a restart reloads the counter anyway.
  assign tmr_tick = CC_LIFE_MANAGER_tick_InHigh && (state_q == STATE_GRACE);

  cc_grace_timer #(
    .GRACE_DATAWIDTH(GRACE_DATAWIDTH)
  ) u_grace_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .tick_i     (tmr_tick),
    .zero_o     (tmr_zero),
    .last_o     (tmr_last)
  );

  // Next-state / next-output logic.
  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    lifelost_d   = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;

    if (CC_LIFE_MANAGER_restart_InHigh) begin
      // Restart discards any coincident hit/bonus.
      state_d  = STATE_PLAY;
      lives_d  = LIVES_INIT;
      tmr_load = 1'b1;
    end else begin
      unique case (state_q)
        STATE_PLAY: begin
          if (CC_LIFE_MANAGER_hit_InHigh) begin
            // An accepted hit swallows a coincident bonus.
            lives_d    = lives_q - LIVES_ONE;
            lifelost_d = 1'b1;
            if (lives_q == LIVES_ONE) begin
              state_d = STATE_GAMEOVER;
            end else begin
              state_d      = STATE_GRACE;
              tmr_load     = 1'b1;
              tmr_load_val = GRACE_LOAD;
            end
          end else if (CC_LIFE_MANAGER_bonus_InHigh && (lives_q < LIVES_MAX)) begin
            lives_d = lives_q + LIVES_ONE;
          end
        end

        STATE_GRACE: begin
          // Hits are ignored while invulnerable; bonuses still count.
          if (CC_LIFE_MANAGER_bonus_InHigh && (lives_q < LIVES_MAX)) begin
            lives_d = lives_q + LIVES_ONE;
          end
          // An empty counter in GRACE cannot occur normally; leaving rather
          // than staying keeps the player from being stuck invulnerable.
          if ((tmr_tick && tmr_last) || tmr_zero) begin
            state_d = STATE_PLAY;
          end
        end

        STATE_GAMEOVER: begin
          lives_d = '0;
        end

        default: begin
          state_d = STATE_PLAY;
          lives_d = LIVES_INIT;
        end
      endcase
    end

    alive_d    = (lives_d != '0);
    gameover_d = (state_d == STATE_GAMEOVER);
    invuln_d   = (state_d == STATE_GRACE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= STATE_PLAY;
      lives_q    <= LIVES_INIT;
      alive_q    <= 1'b1;
      gameover_q <= 1'b0;
      invuln_q   <= 1'b0;
      lifelost_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lives_q    <= lives_d;
      alive_q    <= alive_d;
      gameover_q <= gameover_d;
      invuln_q   <= invuln_d;
      lifelost_q <= lifelost_d;
    end
  end

  assign CC_LIFE_MANAGER_lives_OutBUS     = lives_q;
  assign CC_LIFE_MANAGER_alive_OutHigh    = alive_q;
  assign CC_LIFE_MANAGER_gameover_OutHigh = gameover_q;
  assign CC_LIFE_MANAGER_invuln_OutHigh   = invuln_q;
  assign CC_LIFE_MANAGER_lifelost_OutHigh = lifelost_q;

endmodule

// File: doc/cc_life_manager.md
Name: cc_life_manager

Overview:
- Parametrised successor to the life-zero comparator in the Frogger datapath.
- Holds the player's life count and applies hit (decrement) and bonus (increment, saturating) events.
- After each lost life, runs a frame-tick invulnerability (grace) window.
- Drives registered alive / game-over / invulnerable flags to the game controller and the score/HUD logic.

Parameters:
- LIFE_DATAWIDTH, 3, width of the life count.
- LIFE_INIT, 3, lives loaded on reset and restart. Must satisfy 1 <= LIFE_INIT <= LIFE_MAX.
- LIFE_MAX, 7, saturation ceiling for bonus. Must satisfy LIFE_MAX <= 2^LIFE_DATAWIDTH-1.
- GRACE_TICKS, 60, length of the grace window in frame ticks. Must be >= 1.
- GRACE_DATAWIDTH, 6, width of the grace counter. Must satisfy GRACE_TICKS <= 2^GRACE_DATAWIDTH-1.

Ports:
- CC_LIFE_MANAGER_CLOCK_50  in  1  system clock; all logic on its rising edge.
- CC_LIFE_MANAGER_RESET_InHigh  in  1  synchronous reset, active high.
- CC_LIFE_MANAGER_hit_InHigh  in  1  one-cycle pulse: frog collided or drowned.
- CC_LIFE_MANAGER_bonus_InHigh  in  1  one-cycle pulse: extra life earned.
- CC_LIFE_MANAGER_restart_InHigh  in  1  one-cycle pulse: new game requested.
- CC_LIFE_MANAGER_tick_InHigh  in  1  one-cycle frame-tick strobe (e.g. vsync).
- CC_LIFE_MANAGER_lives_OutBUS  out  LIFE_DATAWIDTH  current life count.
- CC_LIFE_MANAGER_alive_OutHigh  out  1  1 while lives != 0 (the old comparator's output, now registered).
- CC_LIFE_MANAGER_gameover_OutHigh  out  1  1 in GAMEOVER state.
- CC_LIFE_MANAGER_invuln_OutHigh  out  1  1 in GRACE state.
- CC_LIFE_MANAGER_lifelost_OutHigh  out  1  one-cycle pulse on each accepted hit.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high.
  - Reset has priority over every other input.
- Reset values:
  - state = PLAY; lives = LIFE_INIT; grace counter = 0.
  - alive = 1, gameover = 0, invuln = 0, lifelost = 0.
- Output timing: all outputs are registered. Every input event is visible on the outputs exactly 1 cycle after the clock edge that samples it.
- States: PLAY, GRACE, GAMEOVER.
- Priority within a cycle: reset > restart > hit > bonus. tick is independent of the other inputs.
- restart (in any state): lives = LIFE_INIT, state = PLAY, grace counter = 0. Any coincident hit/bonus is discarded.
- PLAY, hit, lives > 1:
  - lives = lives-1; lifelost pulses for 1 cycle.
  - state = GRACE; grace counter = GRACE_TICKS.
- PLAY, hit, lives == 1:
  - lives = 0; lifelost pulses for 1 cycle.
  - state = GAMEOVER; alive = 0; gameover = 1.
- Hit/bonus coincidence: a bonus in the same cycle as an accepted hit is discarded (no net-zero arithmetic).
- PLAY or GRACE, bonus without an accepted hit: lives = min(lives+1, LIFE_MAX). At LIFE_MAX, lives holds and nothing wraps.
- GRACE:
  - Hits are ignored (no decrement, no lifelost).
  - Bonus is still applied.
  - Each tick decrements the grace counter.
  - A tick while the counter == 1 sets the counter to 0 and state = PLAY, so invuln drops 1 cycle later.
  - Exactly GRACE_TICKS ticks are spent in GRACE.
- Hit and last tick in the same cycle while in GRACE: the hit is ignored; the block returns to PLAY.
- GAMEOVER:
  - hit, bonus and tick are ignored.
  - lives holds at 0.
  - Only restart or reset exits.
- Ticks in PLAY have no effect.
- Width rule: lives arithmetic is unsigned in LIFE_DATAWIDTH. Underflow below 0 and overflow above LIFE_MAX are impossible by construction.
- Reset mid-GRACE or mid-GAMEOVER returns to the reset values on the next edge.

Decomposition:
- Shared include cc_life_defs.vh holds:
  - State encoding localparams STATE_PLAY=2'b00, STATE_GRACE=2'b01, STATE_GAMEOVER=2'b10.
  - Default LIFE_* constants, so that the HUD and controller use identical values.
- One sub-module: cc_grace_timer, a loadable down-counter.
  - Ports: load, load value, tick enable.
  - Output: zero flag.
  - Sized by GRACE_DATAWIDTH.
- The top-level FSM and lives register stay in cc_life_manager.

Test Plan:
- Reset check (defaults): assert reset 2 cycles -> lives=3, alive=1, gameover=0, invuln=0, lifelost=0.
- Hit and grace window (GRACE_TICKS=4):
  - Hit in PLAY -> next cycle lives=2, lifelost=1 for exactly 1 cycle, invuln=1.
  - 2 hits during GRACE -> lives stays 2.
  - After the 4th tick -> invuln=0 one cycle later.
- Game over:
  - Three hits, each separated by a full grace window -> lives 2,1,0; alive=0, gameover=1.
  - Further hit/bonus -> no change.
  - restart -> lives=3, PLAY.
- Bonus saturation: 6 bonus pulses from lives=3 with LIFE_MAX=7 -> lives=4,5,6,7,7,7.
- Coincident events:
  - hit+bonus in PLAY with lives=1 -> lives=0, GAMEOVER.
  - restart+hit -> lives=3, no lifelost.
- Reset mid-GRACE (counter=2) -> next cycle invuln=0, lives=3, state PLAY.
